// File: rtl/cnn16_mem_responder_if.sv
// Datapath <-> memory responder handshake bundle; mem_err exists only with CNN16_MEM_BOUND_EN.
interface cnn16_mem_responder_if;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] address;
    logic [15:0] to_memory;
    logic [15:0] from_memory;
    logic        mem_ready;
    logic        mem_busy;
`ifdef CNN16_MEM_BOUND_EN
    logic        mem_err;
`endif

    modport master (
        output mem_req, mem_we, address, to_memory,
`ifdef CNN16_MEM_BOUND_EN
        input  mem_err,
`endif
        input  from_memory, mem_ready, mem_busy
    );

    modport slave (
        input  mem_req, mem_we, address, to_memory,
`ifdef CNN16_MEM_BOUND_EN
        output mem_err,
`endif
        output from_memory, mem_ready, mem_busy
    );
endinterface

// File: rtl/cnn16_mem_responder.sv
// Single-port 16-bit word memory with WAIT_STATES access latency and a one-cycle completion pulse.
// Optional CNN16_MEM_BOUND_EN: flag out-of-range addresses, drop their writes, read them as zero.
module cnn16_mem_responder #(
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cnn16_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] addr_q;
    logic        we_q;
    logic [15:0] wdat_q;
    logic [15:0] rdat_q;
    logic        do_access;
    logic [15:0] mem_q [DEPTH];

    // With zero wait states the access happens on the accept edge itself,
    // so the live inputs stand in for the not-yet-latched copies.
    logic        in_idle;
    logic [11:0] acc_addr;
    logic        acc_we;
    logic [15:0] acc_wdat;
    logic [AW-1:0] idx;
    logic        in_range;

    assign in_idle  = (state_q == S_IDLE);
    assign acc_addr = in_idle ? bus.address   : addr_q;
    assign acc_we   = in_idle ? bus.mem_we    : we_q;
    assign acc_wdat = in_idle ? bus.to_memory : wdat_q;
    assign idx      = acc_addr[AW-1:0];

`ifdef CNN16_MEM_BOUND_EN
    logic err_q;
    assign in_range    = ({1'b0, acc_addr} < 13'(DEPTH));
    assign bus.mem_err = err_q;
`else
    assign in_range = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_req) begin
                    if (WAIT_STATES == 0) begin
                        state_d   = S_RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d   = S_RESP;
                    cnt_d     = 4'd0;
                    do_access = 1'b1;
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdat_q  <= 16'h0000;
`ifdef CNN16_MEM_BOUND_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (do_access && !acc_we)
                rdat_q <= in_range ? mem_q[idx] : 16'h0000;
`ifdef CNN16_MEM_BOUND_EN
            err_q <= do_access && !in_range;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (in_idle && bus.mem_req) begin
            addr_q <= bus.address;
            we_q   <= bus.mem_we;
            wdat_q <= bus.to_memory;
        end
    end

    // Storage is deliberately outside reset; reset only suppresses a commit.
    always_ff @(posedge clk) begin
        if (!rst && do_access && acc_we && in_range)
            mem_q[idx] <= acc_wdat;
    end

    assign bus.from_memory = rdat_q;
    assign bus.mem_ready   = (state_q == S_RESP);
    assign bus.mem_busy    = !in_idle;
endmodule

// File: tb/tb_cnn16_mem_responder.sv
// Directed bench: three responders (WS=1, WS=0, DEPTH=256) sharing clock and reset.
module tb_cnn16_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_a [3];
    logic        we_a  [3];
    logic [11:0] adr_a [3];
    logic [15:0] wd_a  [3];
    logic [15:0] rd_a  [3];
    logic        rdy_a [3];
    logic        bsy_a [3];
    logic        err_a [3];

    int vec = 0;
    int bad = 0;

    cnn16_mem_responder_if if0 ();
    cnn16_mem_responder_if if1 ();
    cnn16_mem_responder_if if2 ();

    assign if0.mem_req = req_a[0];  assign if0.mem_we = we_a[0];
    assign if0.address = adr_a[0];  assign if0.to_memory = wd_a[0];
    assign if1.mem_req = req_a[1];  assign if1.mem_we = we_a[1];
    assign if1.address = adr_a[1];  assign if1.to_memory = wd_a[1];
    assign if2.mem_req = req_a[2];  assign if2.mem_we = we_a[2];
    assign if2.address = adr_a[2];  assign if2.to_memory = wd_a[2];

    assign rd_a[0] = if0.from_memory; assign rdy_a[0] = if0.mem_ready; assign bsy_a[0] = if0.mem_busy;
    assign rd_a[1] = if1.from_memory; assign rdy_a[1] = if1.mem_ready; assign bsy_a[1] = if1.mem_busy;
    assign rd_a[2] = if2.from_memory; assign rdy_a[2] = if2.mem_ready; assign bsy_a[2] = if2.mem_busy;
`ifdef CNN16_MEM_BOUND_EN
    assign err_a[0] = if0.mem_err; assign err_a[1] = if1.mem_err; assign err_a[2] = if2.mem_err;
`else
    assign err_a[0] = 1'b0; assign err_a[1] = 1'b0; assign err_a[2] = 1'b0;
`endif

    cnn16_mem_responder #(.DEPTH(4096), .WAIT_STATES(1)) dut_ws1  (.clk(clk), .rst(rst), .bus(if0.slave));
    cnn16_mem_responder #(.DEPTH(4096), .WAIT_STATES(0)) dut_ws0  (.clk(clk), .rst(rst), .bus(if1.slave));
    cnn16_mem_responder #(.DEPTH(256),  .WAIT_STATES(1)) dut_d256 (.clk(clk), .rst(rst), .bus(if2.slave));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One access; lat = cycles from accept edge to the cycle mem_ready is seen.
    // Inputs are scrambled right after accept to prove they were latched.
    task automatic access(input int d, input logic w, input logic [11:0] a, input logic [15:0] wd,
                          output int lat, output logic [15:0] rd, output logic er, output logic busy);
        req_a[d] = 1'b1; we_a[d] = w; adr_a[d] = a; wd_a[d] = wd;
        cyc();
        req_a[d] = 1'b0; we_a[d] = ~w; adr_a[d] = ~a; wd_a[d] = ~wd;
        busy = bsy_a[d];
        lat = 1;
        while (!rdy_a[d] && lat < 20) begin
            cyc();
            lat++;
        end
        rd = rd_a[d];
        er = err_a[d];
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_a[d] = 1'b0; we_a[d] = 1'b0; adr_a[d] = 12'h000; wd_a[d] = 16'h0000;
        end
        cyc(); cyc();
        for (int d = 0; d < 3; d++) begin
            vec++; if (rd_a[d] !== 16'h0000) begin bad++; $display("FAIL reset_from_memory[%0d]: got %h want 0000", d, rd_a[d]); end
            vec++; if (rdy_a[d] !== 1'b0) begin bad++; $display("FAIL reset_mem_ready[%0d]: got %b want 0", d, rdy_a[d]); end
            vec++; if (bsy_a[d] !== 1'b0) begin bad++; $display("FAIL reset_mem_busy[%0d]: got %b want 0", d, bsy_a[d]); end
            vec++; if (err_a[d] !== 1'b0) begin bad++; $display("FAIL reset_mem_err[%0d]: got %b want 0", d, err_a[d]); end
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic_rw();
        int lat; logic [15:0] rd; logic er; logic bz;
        access(0, 1'b1, 12'h010, 16'hBEEF, lat, rd, er, bz);
        vec++; if (lat !== 2) begin bad++; $display("FAIL basic_write_latency: got %0d want 2", lat); end
        vec++; if (bz !== 1'b1) begin bad++; $display("FAIL basic_write_busy: got %b want 1", bz); end
        vec++; if (rd !== 16'h0000) begin bad++; $display("FAIL basic_write_keeps_rdata: got %h want 0000", rd); end
        access(0, 1'b0, 12'h010, 16'h0000, lat, rd, er, bz);
        vec++; if (lat !== 2) begin bad++; $display("FAIL basic_read_latency: got %0d want 2", lat); end
        vec++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL basic_read_data: got %h want BEEF", rd); end
    endtask

    task automatic test_zero_wait();
        int lat; logic [15:0] rd; logic er; logic bz;
        access(1, 1'b1, 12'h000, 16'h1234, lat, rd, er, bz);
        vec++; if (lat !== 1) begin bad++; $display("FAIL zw_write_latency: got %0d want 1", lat); end
        access(1, 1'b1, 12'hFFF, 16'hA5C3, lat, rd, er, bz);
        access(1, 1'b0, 12'h000, 16'h0000, lat, rd, er, bz);
        vec++; if (lat !== 1) begin bad++; $display("FAIL zw_read_latency: got %0d want 1", lat); end
        vec++; if (rd !== 16'h1234) begin bad++; $display("FAIL zw_read_data: got %h want 1234", rd); end
        access(1, 1'b0, 12'hFFF, 16'h0000, lat, rd, er, bz);
        vec++; if (rd !== 16'hA5C3) begin bad++; $display("FAIL zw_read_top: got %h want A5C3", rd); end
    endtask

    // Request raised during a RESP cycle and held 10 cycles: accepts at cycles 1, 4, 7.
    task automatic test_held_req();
        int accepts = 0;
        logic exp_busy;
        req_a[0] = 1'b1; we_a[0] = 1'b0; adr_a[0] = 12'h010;
        cyc();
        req_a[0] = 1'b0;
        cyc();
        vec++; if (rdy_a[0] !== 1'b1) begin bad++; $display("FAIL held_prelude_ready: got %b want 1", rdy_a[0]); end
        req_a[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            exp_busy = !(c == 1 || c == 4 || c == 7);
            vec++; if (bsy_a[0] !== exp_busy) begin bad++; $display("FAIL held_busy_c%0d: got %b want %b", c, bsy_a[0], exp_busy); end
            if (bsy_a[0] === 1'b0) accepts++;
            cyc();
        end
        req_a[0] = 1'b0;
        vec++; if (accepts !== 3) begin bad++; $display("FAIL held_accept_count: got %0d want 3", accepts); end
        vec++; if (rd_a[0] !== 16'hBEEF) begin bad++; $display("FAIL held_read_data: got %h want BEEF", rd_a[0]); end
        vec++; if (bsy_a[0] !== 1'b0) begin bad++; $display("FAIL held_final_idle: got %b want 0", bsy_a[0]); end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [15:0] rd; logic er; logic bz;
        logic seen = 1'b0;
        access(0, 1'b1, 12'h020, 16'h5555, lat, rd, er, bz);
        req_a[0] = 1'b1; we_a[0] = 1'b1; adr_a[0] = 12'h020; wd_a[0] = 16'hAAAA;
        cyc();
        req_a[0] = 1'b0;
        vec++; if (bsy_a[0] !== 1'b1) begin bad++; $display("FAIL abort_in_wait: got busy %b want 1", bsy_a[0]); end
        rst = 1'b1;
        cyc();
        vec++; if (rdy_a[0] !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", rdy_a[0]); end
        vec++; if (bsy_a[0] !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bsy_a[0]); end
        vec++; if (rd_a[0] !== 16'h0000) begin bad++; $display("FAIL abort_rdata_cleared: got %h want 0000", rd_a[0]); end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (rdy_a[0] !== 1'b0) seen = 1'b1;
            cyc();
        end
        vec++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_late_ready: got %b want 0", seen); end
        access(0, 1'b0, 12'h020, 16'h0000, lat, rd, er, bz);
        vec++; if (rd !== 16'h5555) begin bad++; $display("FAIL abort_no_commit: got %h want 5555", rd); end
    endtask

    task automatic test_bounds();
        int lat; logic [15:0] rd; logic er; logic bz;
        access(2, 1'b1, 12'h000, 16'h0102, lat, rd, er, bz);
        vec++; if (er !== 1'b0) begin bad++; $display("FAIL bound_inrange_err: got %b want 0", er); end
        access(2, 1'b1, 12'h100, 16'h7777, lat, rd, er, bz);
        vec++; if (lat !== 2) begin bad++; $display("FAIL bound_write_latency: got %0d want 2", lat); end
`ifdef CNN16_MEM_BOUND_EN
        vec++; if (er !== 1'b1) begin bad++; $display("FAIL bound_write_err: got %b want 1", er); end
        access(2, 1'b0, 12'h000, 16'h0000, lat, rd, er, bz);
        vec++; if (rd !== 16'h0102) begin bad++; $display("FAIL bound_base_unchanged: got %h want 0102", rd); end
        vec++; if (er !== 1'b0) begin bad++; $display("FAIL bound_base_err: got %b want 0", er); end
        access(2, 1'b0, 12'h100, 16'h0000, lat, rd, er, bz);
        vec++; if (rd !== 16'h0000) begin bad++; $display("FAIL bound_oor_read: got %h want 0000", rd); end
        vec++; if (er !== 1'b1) begin bad++; $display("FAIL bound_oor_read_err: got %b want 1", er); end
        vec++; if (bsy_a[2] !== 1'b0) begin bad++; $display("FAIL bound_err_idle: got busy %b want 0", bsy_a[2]); end
        vec++; if (err_a[2] !== 1'b0) begin bad++; $display("FAIL bound_err_pulse: got %b want 0", err_a[2]); end
`else
        access(2, 1'b0, 12'h000, 16'h0000, lat, rd, er, bz);
        vec++; if (rd !== 16'h7777) begin bad++; $display("FAIL bound_alias_read: got %h want 7777", rd); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_rw();
        test_zero_wait();
        test_held_req();
        test_reset_mid_write();
        test_bounds();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
